// File: rtl/sdram_rr_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sdram_rr_scheduler_if : master-side and SDRAM-side bus bundle     |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
interface sdram_rr_scheduler_if #(
  parameter int PADD_SIZE = 24,
  parameter int CMD_SIZE  = 3,
  parameter int DATA_SIZE = 32,
  parameter int FIFO_SIZE = 8
);
  logic [2:0]           i_bus_request;
  logic                 i_sdram_busy;
  logic                 i_sdram_ack;
  logic [FIFO_SIZE-1:0] i_dma_dataout;
  logic [PADD_SIZE-1:0] i_dma_addr;
  logic [CMD_SIZE-1:0]  i_dma_cmd;
  logic [DATA_SIZE-1:0] i_dcache_dataout;
  logic [PADD_SIZE-1:0] i_dcache_addr;
  logic [CMD_SIZE-1:0]  i_dcache_cmd;
  logic [DATA_SIZE-1:0] i_icache_dataout;
  logic [PADD_SIZE-1:0] i_icache_addr;
  logic [CMD_SIZE-1:0]  i_icache_cmd;
  logic [DATA_SIZE-1:0] i_sdram_dataout;

  logic [2:0]           o_bus_grant;
  logic                 o_owner_valid;
  logic [FIFO_SIZE-1:0] o_dma_datain;
  logic [DATA_SIZE-1:0] o_dcache_datain;
  logic [DATA_SIZE-1:0] o_icache_datain;
  logic [PADD_SIZE-1:0] o_sdram_addr;
  logic [CMD_SIZE-1:0]  o_sdram_cmd;
  logic [DATA_SIZE-1:0] o_sdram_datain;

  modport slave (
    input  i_bus_request, i_sdram_busy, i_sdram_ack,
    input  i_dma_dataout, i_dma_addr, i_dma_cmd,
    input  i_dcache_dataout, i_dcache_addr, i_dcache_cmd,
    input  i_icache_dataout, i_icache_addr, i_icache_cmd,
    input  i_sdram_dataout,
    output o_bus_grant, o_owner_valid, o_dma_datain, o_dcache_datain,
    output o_icache_datain, o_sdram_addr, o_sdram_cmd, o_sdram_datain
  );

  modport master (
    output i_bus_request, i_sdram_busy, i_sdram_ack,
    output i_dma_dataout, i_dma_addr, i_dma_cmd,
    output i_dcache_dataout, i_dcache_addr, i_dcache_cmd,
    output i_icache_dataout, i_icache_addr, i_icache_cmd,
    output i_sdram_dataout,
    input  o_bus_grant, o_owner_valid, o_dma_datain, o_dcache_datain,
    input  o_icache_datain, o_sdram_addr, o_sdram_cmd, o_sdram_datain
  );
endinterface
`default_nettype wire

// File: rtl/sdram_rr_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sdram_rr_scheduler : round-robin SDRAM port arbiter (DMA/D$/I$)   |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module sdram_rr_scheduler #(
  parameter int PADD_SIZE = 24,
  parameter int CMD_SIZE  = 3,
  parameter int DATA_SIZE = 32,
  parameter int FIFO_SIZE = 8,
  parameter int MAX_BURST = 8
) (
  input  wire logic           clk0,
  input  wire logic           reset,
  sdram_rr_scheduler_if.slave bus
);

  localparam logic [3:0] c_MAX_BURST = 4'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_GRANT = 3'b010,
    S_TURN  = 3'b100
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_grant, w_grant_nxt;
  logic [3:0] r_burst, w_burst_nxt;
  logic [1:0] r_ptr,   w_ptr_nxt;

  logic [1:0] w_ptr;
  logic [2:0] w_arb_grant;
  logic [1:0] w_own_idx;
  logic       w_own_ok;
  logic       w_own_req;
  logic       w_others;

  function automatic logic [1:0] f_wrap(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  assign w_ptr = (r_ptr == 2'd3) ? 2'd0 : r_ptr;

  // Scan from the far end so the candidate closest to the pointer is the last write.
  always_comb begin
    w_arb_grant = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (bus.i_bus_request[f_wrap({1'b0, w_ptr} + 3'(i))])
        w_arb_grant = 3'b001 << f_wrap({1'b0, w_ptr} + 3'(i));
    end
  end

  always_comb begin
    case (r_grant)
      3'b010:  w_own_idx = 2'd1;
      3'b100:  w_own_idx = 2'd2;
      default: w_own_idx = 2'd0;
    endcase
  end

  assign w_own_ok  = (r_grant == 3'b001) || (r_grant == 3'b010) || (r_grant == 3'b100);
  assign w_own_req = |(bus.i_bus_request & r_grant);
  assign w_others  = |(bus.i_bus_request & ~r_grant);

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= 3'b000;
      r_burst <= 4'd0;
      r_ptr   <= 2'd1;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_burst <= w_burst_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_burst_nxt = r_burst;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE, S_TURN: begin
        w_burst_nxt = 4'd0;
        if (|w_arb_grant) begin
          w_grant_nxt = w_arb_grant;
          w_state_nxt = S_GRANT;
        end else begin
          w_grant_nxt = 3'b000;
          w_state_nxt = S_IDLE;
        end
      end
      S_GRANT: begin
        if (bus.i_sdram_ack && (r_burst < c_MAX_BURST))
          w_burst_nxt = r_burst + 4'd1;
        if (!w_own_ok) begin
          w_grant_nxt = 3'b000;
          w_state_nxt = S_IDLE;
        end else if (!bus.i_sdram_busy &&
                     (!w_own_req || ((r_burst == c_MAX_BURST) && w_others))) begin
          w_grant_nxt = 3'b000;
          w_state_nxt = S_TURN;
          w_ptr_nxt   = (w_own_idx == 2'd2) ? 2'd0 : w_own_idx + 2'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 3'b000;
        w_burst_nxt = 4'd0;
      end
    endcase
  end

  logic [PADD_SIZE-1:0] w_addr;
  logic [CMD_SIZE-1:0]  w_cmd;
  logic [DATA_SIZE-1:0] w_wdata;
  logic [FIFO_SIZE-1:0] w_dma_rd;
  logic [DATA_SIZE-1:0] w_dc_rd;
  logic [DATA_SIZE-1:0] w_ic_rd;

  always_comb begin
    w_addr   = '0;
    w_cmd    = '0;
    w_wdata  = '0;
    w_dma_rd = '0;
    w_dc_rd  = '0;
    w_ic_rd  = '0;
    case (r_grant)
      3'b001: begin
        w_addr   = bus.i_dma_addr;
        w_cmd    = bus.i_dma_cmd;
        w_wdata  = DATA_SIZE'(bus.i_dma_dataout);
        w_dma_rd = bus.i_sdram_dataout[FIFO_SIZE-1:0];
      end
      3'b010: begin
        w_addr  = bus.i_dcache_addr;
        w_cmd   = bus.i_dcache_cmd;
        w_wdata = bus.i_dcache_dataout;
        w_dc_rd = bus.i_sdram_dataout;
      end
      3'b100: begin
        w_addr  = bus.i_icache_addr;
        w_cmd   = bus.i_icache_cmd;
        w_wdata = bus.i_icache_dataout;
        w_ic_rd = bus.i_sdram_dataout;
      end
      default: ;
    endcase
  end

  assign bus.o_bus_grant     = r_grant;
  assign bus.o_owner_valid   = |r_grant;
  assign bus.o_sdram_addr    = w_addr;
  assign bus.o_sdram_cmd     = w_cmd;
  assign bus.o_sdram_datain  = w_wdata;
  assign bus.o_dma_datain    = w_dma_rd;
  assign bus.o_dcache_datain = w_dc_rd;
  assign bus.o_icache_datain = w_ic_rd;

endmodule
`default_nettype wire
